// File: rtl/mem_ctrl_pkg.sv
// Shared CPU memory-access definitions: access sizes, controller states, byte-count helper.
package mem_ctrl_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_RSVD = 2'd1,
      SZ_HALF = 2'd2,
      SZ_BYTE = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Index of the last byte lane touched by an access of the given size (reserved acts as word).
   function automatic logic [IDX_W-1:0] last_index(input size_e sz);
      case (sz)
         SZ_HALF: last_index = 2'd1;
         SZ_BYTE: last_index = 2'd0;
         default: last_index = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating MEM-stage and fetch requests onto an 8-bit RAM port.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              mm_e,
   input  logic [XLEN-1:0]   mm_a,
   input  logic              mm_wr,
   input  logic [1:0]        mm_cu,
   input  logic [XLEN-1:0]   mm_n_i,
   output logic [XLEN-1:0]   mm_n_o,
   output logic              mm_ok,
   input  logic              if_e,
   input  logic [XLEN-1:0]   if_a,
   output logic [XLEN-1:0]   if_n_o,
   output logic              if_ok,
   input  logic [BYTE_W-1:0] mem_din,
   output logic [BYTE_W-1:0] mem_dout,
   output logic [XLEN-1:0]   mem_a,
   output logic              mem_wr
);

   state_e            state;
   logic [IDX_W-1:0]  cnt;
   logic [IDX_W-1:0]  last_q;
   logic              primed;
   logic              owner_if;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rbuf;

   logic [IDX_W-1:0]  cnt_nxt;
   logic [IDX_W:0]    issue_nxt;
   logic [XLEN-1:0]   rbuf_ins;
   logic [BYTE_W-1:0] wbyte_nxt;

   // Next byte index, next read byte to issue, read buffer with current lane filled, next write byte.
   always_comb begin
      cnt_nxt   = cnt + 2'd1;
      issue_nxt = 3'(cnt) + 3'd2;
      rbuf_ins  = rbuf;
      rbuf_ins[{cnt, 3'b000} +: BYTE_W] = mem_din;
      wbyte_nxt = 8'(wdata_q >> {cnt_nxt, 3'b000});
   end

   // Controller FSM with registered RAM-side and requester-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         last_q   <= '0;
         primed   <= 1'b0;
         owner_if <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rbuf     <= '0;
         mm_n_o   <= '0;
         mm_ok    <= 1'b0;
         if_n_o   <= '0;
         if_ok    <= 1'b0;
         mem_dout <= '0;
         mem_a    <= '0;
         mem_wr   <= 1'b0;
      end else begin
         mm_ok <= 1'b0;
         if_ok <= 1'b0;
         case (state)
            IDLE: begin
               if (mm_e || if_e) begin
                  owner_if <= !mm_e;
                  addr_q   <= mm_e ? mm_a : if_a;
                  last_q   <= mm_e ? last_index(size_e'(mm_cu)) : last_index(SZ_WORD);
                  wdata_q  <= mm_n_i;
                  cnt      <= '0;
                  primed   <= 1'b0;
                  rbuf     <= '0;
                  mem_a    <= mm_e ? mm_a : if_a;
                  if (mm_e && mm_wr) begin
                     state    <= WRITE;
                     mem_wr   <= 1'b1;
                     mem_dout <= mm_n_i[BYTE_W-1:0];
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (owner_if && !if_e) begin
                  // Fetch withdrawn: drop it silently.
                  state <= IDLE;
                  mem_a <= '0;
               end else if (!primed) begin
                  // First byte is still in flight; only issue the second address.
                  primed <= 1'b1;
                  mem_a  <= (last_q != 2'd0) ? addr_q + 32'd1 : '0;
               end else begin
                  rbuf <= rbuf_ins;
                  if (cnt == last_q) begin
                     state <= DONE;
                     mem_a <= '0;
                     if (owner_if) begin
                        if_n_o <= rbuf_ins;
                        if_ok  <= 1'b1;
                     end else begin
                        mm_n_o <= rbuf_ins;
                        mm_ok  <= 1'b1;
                     end
                  end else begin
                     cnt   <= cnt_nxt;
                     mem_a <= (issue_nxt <= {1'b0, last_q}) ? addr_q + 32'(issue_nxt) : '0;
                  end
               end
            end
            WRITE: begin
               if (cnt == last_q) begin
                  state    <= DONE;
                  mm_ok    <= 1'b1;
                  mem_wr   <= 1'b0;
                  mem_a    <= '0;
                  mem_dout <= '0;
               end else begin
                  cnt      <= cnt_nxt;
                  mem_a    <= addr_q + 32'(cnt_nxt);
                  mem_dout <= wbyte_nxt;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

   localparam int NT = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        mm_e, mm_wr, if_e;
   logic [31:0] mm_a, mm_n_i, if_a;
   logic [1:0]  mm_cu;
   logic [31:0] mm_n_o, if_n_o, mem_a;
   logic        mm_ok, if_ok, mem_wr;
   logic [7:0]  mem_din, mem_dout;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  ram [0:4095];

   logic [31:0] t_a   [NT];
   logic        t_wr  [NT];
   logic [7:0]  t_do  [NT];
   logic        t_mok [NT];
   logic        t_iok [NT];
   logic [31:0] t_md  [NT];
   logic [31:0] t_id  [NT];

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .mm_e     (mm_e),
      .mm_a     (mm_a),
      .mm_wr    (mm_wr),
      .mm_cu    (mm_cu),
      .mm_n_i   (mm_n_i),
      .mm_n_o   (mm_n_o),
      .mm_ok    (mm_ok),
      .if_e     (if_e),
      .if_a     (if_a),
      .if_n_o   (if_n_o),
      .if_ok    (if_ok),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .mem_a    (mem_a),
      .mem_wr   (mem_wr)
   );

   // RAM: data for the address of cycle c-1 appears in cycle c; writes land at the edge.
   always @(posedge clk) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int first_mok();
      for (int k = 0; k < NT; k++) if (t_mok[k]) return k;
      return -1;
   endfunction

   function automatic int first_iok();
      for (int k = 0; k < NT; k++) if (t_iok[k]) return k;
      return -1;
   endfunction

   function automatic int count_mok();
      int n = 0;
      for (int k = 0; k < NT; k++) if (t_mok[k]) n++;
      return n;
   endfunction

   function automatic int count_iok();
      int n = 0;
      for (int k = 0; k < NT; k++) if (t_iok[k]) n++;
      return n;
   endfunction

   function automatic int count_wr();
      int n = 0;
      for (int k = 0; k < NT; k++) if (t_wr[k]) n++;
      return n;
   endfunction

   // Raise requests in the current cycle (c0-1), then record NT cycles; index k is cycle c0+k.
   task automatic run(input logic me, input logic ie, input logic wr, input logic [1:0] cu,
                      input logic [31:0] ma, input logic [31:0] md, input logic [31:0] ia,
                      input int drop_mm_at, input int drop_if_at, input int rst_at);
      mm_e = me; mm_wr = wr; mm_cu = cu; mm_a = ma; mm_n_i = md;
      if_e = ie; if_a = ia;
      for (int k = 0; k < NT; k++) begin
         @(posedge clk); #1;
         t_a[k]   = mem_a;
         t_wr[k]  = mem_wr;
         t_do[k]  = mem_dout;
         t_mok[k] = mm_ok;
         t_iok[k] = if_ok;
         t_md[k]  = mm_n_o;
         t_id[k]  = if_n_o;
         if (mm_ok || k == drop_mm_at) mm_e = 1'b0;
         if (if_ok || k == drop_if_at) if_e = 1'b0;
         if (k == rst_at) begin
            rst = 1'b1; mm_e = 1'b0; if_e = 1'b0;
         end else begin
            rst = 1'b0;
         end
      end
      mm_e = 1'b0; if_e = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      ram[12'h204] = 8'h77;
      ram[12'h010] = 8'hBE; ram[12'h011] = 8'hEF;
      ram[12'h000] = 8'hDE; ram[12'h001] = 8'hAD; ram[12'h002] = 8'hBE; ram[12'h003] = 8'hEF;
      ram[12'hFFE] = 8'h01; ram[12'hFFF] = 8'h02;

      rst = 1'b1; mm_e = 1'b0; if_e = 1'b0; mm_wr = 1'b0; mm_cu = 2'd0;
      mm_a = '0; mm_n_i = '0; if_a = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_ctl", {28'h0, mem_wr, mm_ok, if_ok, 1'b0}, 32'h0);
      check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
      check("rst_data", mm_n_o | if_n_o, 32'h0);

      // Word read at 0x100.
      run(1, 0, 0, 2'd0, 32'h100, 32'h0, 32'h0, -1, -1, -1);
      check("wr_rd_ok_cycle", 32'(first_mok()), 32'd5);
      check("wr_rd_ok_count", 32'(count_mok()), 32'd1);
      check("wr_rd_data", t_md[5], 32'h44332211);
      check("wr_rd_a0", t_a[0], 32'h100);
      check("wr_rd_a3", t_a[3], 32'h103);
      check("wr_rd_a4_idle", t_a[4], 32'h0);
      check("wr_rd_no_wr", 32'(count_wr()), 32'd0);

      // Byte write of 0xA5 at 0x203.
      run(1, 0, 1, 2'd3, 32'h203, 32'h1234_56A5, 32'h0, -1, -1, -1);
      check("bw_wr_count", 32'(count_wr()), 32'd1);
      check("bw_addr", t_a[0], 32'h203);
      check("bw_dout", {24'h0, t_do[0]}, 32'hA5);
      check("bw_ok_cycle", 32'(first_mok()), 32'd1);
      check("bw_ram_203", {24'h0, ram[12'h203]}, 32'hA5);
      check("bw_ram_204", {24'h0, ram[12'h204]}, 32'h77);
      check("bw_hold_mm_n_o", t_md[5], 32'h44332211);

      // Simultaneous half read at 0x10 and fetch at 0x0.
      run(1, 1, 0, 2'd2, 32'h10, 32'h0, 32'h0, -1, -1, -1);
      check("sim_mm_ok_cycle", 32'(first_mok()), 32'd3);
      check("sim_mm_data", t_md[3], 32'h0000EFBE);
      check("sim_if_ok_cycle", 32'(first_iok()), 32'd10);
      check("sim_if_data", t_id[10], 32'hEFBEADDE);
      check("sim_a1", t_a[1], 32'h11);
      check("sim_gap", t_a[2] | t_a[3] | t_a[4], 32'h0);
      check("sim_if_a1", t_a[6], 32'h1);
      check("sim_if_a3", t_a[8], 32'h3);

      // Word read wrapping through 0xFFFFFFFF.
      run(1, 0, 0, 2'd0, 32'hFFFF_FFFE, 32'h0, 32'h0, -1, -1, -1);
      check("wrap_a0", t_a[0], 32'hFFFF_FFFE);
      check("wrap_a1", t_a[1], 32'hFFFF_FFFF);
      check("wrap_a2", t_a[2], 32'h0);
      check("wrap_a3", t_a[3], 32'h1);
      check("wrap_data", t_md[5], 32'hADDE_0201);

      // Fetch aborted in c0+2, then a byte read is served normally.
      run(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, -1, 2, -1);
      check("abort_a2", t_a[2], 32'h2);
      check("abort_a3_idle", t_a[3], 32'h0);
      check("abort_no_if_ok", 32'(count_iok()), 32'd0);
      check("abort_if_hold", t_id[5], 32'hEFBEADDE);
      run(1, 0, 0, 2'd3, 32'h101, 32'h0, 32'h0, -1, -1, -1);
      check("after_abort_ok_cycle", 32'(first_mok()), 32'd2);
      check("after_abort_data", t_md[2], 32'h0000_0022);

      // Reset in c0+1 of a word write.
      run(1, 0, 1, 2'd0, 32'h300, 32'hCAFE_F00D, 32'h0, -1, -1, 1);
      check("rstw_wr1", {31'h0, t_wr[1]}, 32'h1);
      check("rstw_wr2", {31'h0, t_wr[2]}, 32'h0);
      check("rstw_a2", t_a[2], 32'h0);
      check("rstw_wr_count", 32'(count_wr()), 32'd2);
      check("rstw_no_ok", 32'(count_mok()), 32'd0);
      check("rstw_data_clr", t_md[3], 32'h0);

      // Word write at 0x300.
      run(1, 0, 1, 2'd0, 32'h300, 32'h1234_5678, 32'h0, -1, -1, -1);
      check("ww_ok_cycle", 32'(first_mok()), 32'd4);
      check("ww_dout3", {24'h0, t_do[3]}, 32'h12);
      check("ww_a3", t_a[3], 32'h303);
      check("ww_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'h1234_5678);

      // Word read with mm_e dropped in c0+1 still completes.
      run(1, 0, 0, 2'd0, 32'h300, 32'h0, 32'h0, 1, -1, -1);
      check("drop_ok_cycle", 32'(first_mok()), 32'd5);
      check("drop_data", t_md[5], 32'h1234_5678);

      // Reserved size encoding behaves as a word.
      run(1, 0, 0, 2'd1, 32'h100, 32'h0, 32'h0, -1, -1, -1);
      check("rsvd_ok_cycle", 32'(first_mok()), 32'd5);
      check("rsvd_data", t_md[5], 32'h44332211);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port clk  in  1  system clock, rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port mm_e  in  1  MEM-stage request valid; held high until mm_ok.
REQ-004 SHALL have port mm_a  in  32  MEM-stage byte address.
REQ-005 SHALL have port mm_wr  in  1  MEM-stage request type; 1 = write, 0 = read.
REQ-006 SHALL have port mm_cu  in  2  MEM-stage access size; 0 = word, 2 = half, 3 = byte, 1 = reserved (treated as word).
REQ-007 SHALL have port mm_n_i  in  32  MEM-stage write data; low bytes used.
REQ-008 SHALL have port mm_n_o  out  32  MEM-stage read data, little-endian, zero-extended.
REQ-009 SHALL have port mm_ok  out  1  MEM-stage completion pulse.
REQ-010 SHALL have port if_e  in  1  fetch request valid; always a word read.
REQ-011 SHALL have port if_a  in  32  fetch address.
REQ-012 SHALL have port if_n_o  out  32  fetched instruction.
REQ-013 SHALL have port if_ok  out  1  fetch completion pulse.
REQ-014 SHALL have port mem_din  in  8  RAM read byte.
REQ-015 SHALL have port mem_dout  out  8  RAM write byte.
REQ-016 SHALL have port mem_a  out  32  RAM byte address.
REQ-017 SHALL have port mem_wr  out  1  RAM write strobe; 1 = write this cycle.

Function
REQ-018 SHALL use RAM timing in which mem_din in cycle c holds the byte at the mem_a driven in cycle c-1.
REQ-019 SHALL implement states IDLE, READ, WRITE, DONE, with all outputs registered.
REQ-020 SHALL accept a request in IDLE at a rising edge where mm_e or if_e is high; the accepting cycle is c0-1.
REQ-021 SHALL give mm_e priority when mm_e and if_e are both high; the fetch waits and is accepted in the next IDLE cycle.
REQ-022 SHALL latch address, size, type, data and owner at acceptance, with N = 4, 2 or 1 bytes.
REQ-023 SHALL, for a read, drive mem_a = a+i, mem_wr = 0 in cycle c0+i (i = 0..N-1) and capture mem_din into byte lane i at the end of cycle c0+i+1.
REQ-024 SHALL, for a read, assert the owner's ok for exactly one cycle in cycle c0+N+1, with its data output valid in that cycle and unused upper lanes set to 0.
REQ-025 SHALL, for a write, drive mem_a = a+i, mem_dout = byte i of data and mem_wr = 1 in cycle c0+i, then assert mm_ok for one cycle in cycle c0+N.
REQ-026 SHALL compute addresses modulo 2^32, so a+i wraps from 0xFFFFFFFF to 0.
REQ-027 SHALL handle misaligned addresses byte-serially with no trap.
REQ-028 SHALL return to IDLE from DONE after one cycle; a request still high in that DONE cycle is not re-accepted until IDLE.
REQ-029 SHALL abort an IF read whose if_e drops mid-transaction: return to IDLE next cycle with no if_ok.
REQ-030 SHALL complete an MEM transaction whose mm_e drops mid-transaction, including the mm_ok pulse.
REQ-031 SHALL drive mem_wr = 0, mem_a = 0 and mem_dout = 0 whenever not in READ or WRITE.
REQ-032 SHALL hold mm_n_o and if_n_o at their last completed value between transactions.

Reset
REQ-033 SHALL, while rst is high at a rising edge, force state IDLE and all outputs and internal registers to 0.
REQ-034 SHALL, on rst asserted mid-transaction, abandon that transaction with no ok pulse and mem_wr = 0 from the next cycle.

Structure
REQ-035 SHALL take size encodings (WORD = 0, HALF = 2, BYTE = 3) and the state enumeration from the shared CPU package also used by the MEM stage.
REQ-036 SHALL be a single module with no sub-module; byte index counter is 2 bits.

Verification
REQ-037 SHALL cover word read: RAM[0x100..0x103] = 11,22,33,44, mm_e at 0x100, cu = 0 -> mm_n_o = 0x44332211, mm_ok only in cycle c0+5.
REQ-038 SHALL cover byte write: mm_a = 0x203, cu = 3, data 0xA5 -> single cycle with mem_wr = 1 at 0x203, mm_ok in c0+1, RAM[0x204] unchanged.
REQ-039 SHALL cover simultaneous requests: mm_e (half read at 0x10) and if_e (0x0) in the same cycle -> MEM served first, if_ok follows, no overlap of mem_a sequences.
REQ-040 SHALL cover wrap: word read at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
REQ-041 SHALL cover fetch abort: if_e dropped in c0+2 -> no if_ok, IDLE next cycle, next mm_e accepted.
REQ-042 SHALL cover reset during write: rst in c0+1 of a word write -> mem_wr = 0 from c0+2, no mm_ok.
